// File: rtl/div_issue_hilo_pkg.sv
// Shared definitions for the divide issue / HI-LO controller.
package div_issue_hilo_pkg;

    // Controller FSM encoding.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Divider result viewed as two W-bit halves: index 1 is the upper half.
    localparam int unsigned QuotSlot = 1;  // quotient lives in the upper half
    localparam int unsigned RemSlot  = 0;  // remainder lives in the lower half

endpackage

// File: rtl/div_issue_hilo_if.sv
// Pipeline / divider bundle seen by the divide issue controller.
interface div_issue_hilo_if #(
    parameter int unsigned W = 32
) ();
    // Pipeline side
    logic           int_flush;
    logic           ex_valid;
    logic           op_div;
    logic           op_divu;
    logic           op_mthi;
    logic           op_mtlo;
    logic [W-1:0]   rs_data;
    logic [W-1:0]   rt_data;
    logic           stall_req;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           div_timeout;
    // Divider side
    logic           div_start;
    logic           div_sign;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic [2*W-1:0] div_result;
    logic           div_ok;

    // Controller view.
    modport slave (
        input  int_flush, ex_valid, op_div, op_divu, op_mthi, op_mtlo, rs_data, rt_data,
        input  div_result, div_ok,
        output stall_req, hi, lo, div_timeout, div_start, div_sign, div_a, div_b
    );

    // Environment view (pipeline plus divider).
    modport master (
        output int_flush, ex_valid, op_div, op_divu, op_mthi, op_mtlo, rs_data, rt_data,
        output div_result, div_ok,
        input  stall_req, hi, lo, div_timeout, div_start, div_sign, div_a, div_b
    );
endinterface

// File: rtl/div_issue_hilo_regs.sv
// Architectural HI/LO register pair with independent write ports.
module div_issue_hilo_regs #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         hi_we_i,
    input  logic [W-1:0] hi_wdata_i,
    input  logic         lo_we_i,
    input  logic [W-1:0] lo_wdata_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    // HI and LO update independently on their own enables.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we_i) hi_q <= hi_wdata_i;
            if (lo_we_i) lo_q <= lo_wdata_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: rtl/div_issue_hilo.sv
// EX-stage divide issue controller: launches the divider, stalls until it answers,
// retires quotient/remainder into LO/HI, and services MTHI/MTLO.
module div_issue_hilo
    import div_issue_hilo_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             resetn,
    div_issue_hilo_if.slave bus
);
    localparam int unsigned   CntW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    state_e          state_q, state_d;
    logic            start_q, start_d;
    logic            sign_q,  sign_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [CntW-1:0] cnt_q,   cnt_d;
    logic            tmo_q,   tmo_d;

    logic            is_div;
    logic            wdog_hit;
    logic            hi_we, lo_we;
    logic [W-1:0]    hi_wdata, lo_wdata;
    logic [W-1:0]    hi_w, lo_w;
    logic [1:0][W-1:0] res_halves;

    assign is_div     = bus.ex_valid & (bus.op_div | bus.op_divu);
    assign wdog_hit   = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);
    assign res_halves = bus.div_result;

    // DONE is the single cycle that lets the retiring DIV leave EX.
    assign bus.stall_req = is_div & (state_q != StDone) & ~bus.int_flush;

    // Next-state, operand capture, watchdog and HI/LO write decode.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        sign_d   = sign_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = bus.rs_data;
        lo_wdata = bus.rs_data;

        if (bus.int_flush) begin
            // Flush beats everything, including a coincident div_ok.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (is_div) begin
                        a_d     = bus.rs_data;
                        b_d     = bus.rt_data;
                        sign_d  = bus.op_div;
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        hi_we = bus.ex_valid & bus.op_mthi;
                        lo_we = bus.ex_valid & bus.op_mtlo;
                    end
                end
                StBusy: begin
                    cnt_d = cnt_q + CntW'(1);
                    if (bus.div_ok) begin
                        lo_wdata = res_halves[QuotSlot];
                        hi_wdata = res_halves[RemSlot];
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        state_d  = StDone;
                    end else if (wdog_hit) begin
                        tmo_d   = 1'b1;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Controller state, operand latches, watchdog counter and sticky error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            sign_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            sign_q  <= sign_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    div_issue_hilo_regs #(
        .W (W)
    ) u_regs (
        .clk        (clk),
        .resetn     (resetn),
        .hi_we_i    (hi_we),
        .hi_wdata_i (hi_wdata),
        .lo_we_i    (lo_we),
        .lo_wdata_i (lo_wdata),
        .hi_o       (hi_w),
        .lo_o       (lo_w)
    );

    assign bus.hi          = hi_w;
    assign bus.lo          = lo_w;
    assign bus.div_start   = start_q;
    assign bus.div_sign    = sign_q;
    assign bus.div_a       = a_q;
    assign bus.div_b       = b_q;
    assign bus.div_timeout = tmo_q;
endmodule

// File: tb/tb_div_issue_hilo.sv
// Randomised bench for div_issue_hilo with an emulated variable-latency divider.
module tb_div_issue_hilo;
    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 8;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    div_issue_hilo_if #(.W(W)) bus ();

    div_issue_hilo #(
        .W       (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference architectural state.
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;
    logic        exp_tmo = 1'b0;

    // Divider emulation controls.
    int unsigned dv_lat   = 5;
    bit          dv_mute  = 1'b0;
    int          inj_cnt  = 0;
    int          inj_done = 0;
    logic [63:0] inj_val  = '0;
    int          dv_cnt   = 0;
    logic [63:0] dv_res   = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Divider behaviour: {quotient, remainder}; divide by zero gives all-ones / dividend.
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Divider: answers dv_lat cycles after seeing div_start; can also be forced to pulse.
    initial begin
        bus.div_ok     = 1'b0;
        bus.div_result = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.div_ok = 1'b0;
            if (dv_cnt > 0) begin
                dv_cnt--;
                if (dv_cnt == 0 && !dv_mute) begin
                    bus.div_ok     = 1'b1;
                    bus.div_result = dv_res;
                end
            end
            if (inj_cnt != inj_done) begin
                bus.div_ok     = 1'b1;
                bus.div_result = inj_val;
                inj_done       = inj_cnt;
            end
            if (bus.div_start) begin
                dv_cnt = int'(dv_lat);
                dv_res = div_model(bus.div_a, bus.div_b, bus.div_sign);
            end
        end
    end

    task automatic drive_idle();
        @(negedge clk);
        bus.ex_valid  = 1'b0;
        bus.op_div    = 1'b0;
        bus.op_divu   = 1'b0;
        bus.op_mthi   = 1'b0;
        bus.op_mtlo   = 1'b0;
        bus.int_flush = 1'b0;
    endtask

    task automatic drive_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.ex_valid  = 1'b1;
        bus.op_div    = s;
        bus.op_divu   = ~s;
        bus.op_mthi   = 1'b0;
        bus.op_mtlo   = 1'b0;
        bus.int_flush = 1'b0;
        bus.rs_data   = a;
        bus.rt_data   = b;
    endtask

    // Full DIV/DIVU: holds the instruction in EX until stall_req drops.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned lat, input bit mute);
        int n;
        bit released;
        int unsigned exp_n;
        logic [63:0] r;
        dv_lat  = lat;
        dv_mute = mute;
        @(negedge clk);
        drive_div(s, a, b);
        n = 0;
        released = 1'b0;
        while (n < 64) begin
            #1;
            if (n == 1) begin
                check_val("start_pulse", 64'(bus.div_start), 64'd1);
                check_val("div_sign", 64'(bus.div_sign), 64'(s));
                check_val("div_a", 64'(bus.div_a), 64'(a));
                check_val("div_b", 64'(bus.div_b), 64'(b));
            end else if (n == 2) begin
                check_val("start_drop", 64'(bus.div_start), 64'd0);
            end
            if (mute && n == int'(TMO) + 1)
                check_val("timeout_early", 64'(bus.div_timeout), 64'(exp_tmo));
            if (!bus.stall_req) begin
                released = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
            bus.rs_data = $urandom;  // latched operands must not follow rs/rt
            bus.rt_data = $urandom;
        end
        check_val("released", 64'(released), 64'd1);
        exp_n = mute ? TMO + 2 : lat + 2;
        check_val("release_cycle", 64'(n), 64'(exp_n));
        if (!mute) begin
            r = div_model(a, b, s);
            exp_lo = r[63:32];
            exp_hi = r[31:0];
        end else begin
            exp_tmo = 1'b1;
        end
        check_val("hi", 64'(bus.hi), 64'(exp_hi));
        check_val("lo", 64'(bus.lo), 64'(exp_lo));
        check_val("timeout", 64'(bus.div_timeout), 64'(exp_tmo));
    endtask

    task automatic do_mt(input bit to_hi, input logic [31:0] v);
        @(negedge clk);
        bus.ex_valid = 1'b1;
        bus.op_div   = 1'b0;
        bus.op_divu  = 1'b0;
        bus.op_mthi  = to_hi;
        bus.op_mtlo  = ~to_hi;
        bus.rs_data  = v;
        #1;
        check_val("mt_stall", 64'(bus.stall_req), 64'd0);
        if (to_hi) exp_hi = v;
        else exp_lo = v;
        drive_idle();
        #1;
        check_val("mt_hi", 64'(bus.hi), 64'(exp_hi));
        check_val("mt_lo", 64'(bus.lo), 64'(exp_lo));
    endtask

    task automatic settle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            check_val("idle_stall", 64'(bus.stall_req), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hi"}, 64'(bus.hi), 64'd0);
        check_val({tag, "_lo"}, 64'(bus.lo), 64'd0);
        check_val({tag, "_start"}, 64'(bus.div_start), 64'd0);
        check_val({tag, "_sign"}, 64'(bus.div_sign), 64'd0);
        check_val({tag, "_a"}, 64'(bus.div_a), 64'd0);
        check_val({tag, "_b"}, 64'(bus.div_b), 64'd0);
        check_val({tag, "_tmo"}, 64'(bus.div_timeout), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [31:0] a, b;
        int unsigned op, lat;
        bus.int_flush = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.op_div    = 1'b0;
        bus.op_divu   = 1'b0;
        bus.op_mthi   = 1'b0;
        bus.op_mtlo   = 1'b0;
        bus.rs_data   = '0;
        bus.rt_data   = '0;
        #1 resetn = 1'b0;
        #2;
        check_reset_outputs("reset");
        check_val("reset_stall", 64'(bus.stall_req), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Directed divides.
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 5, 1'b0);
        drive_idle();
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 5, 1'b0);
        drive_idle();

        // MTHI / MTLO.
        do_mt(1'b1, 32'h1234);
        do_mt(1'b0, 32'h5678);

        // Flush two cycles after issue; the divider's late answer must be ignored.
        dv_lat  = 5;
        dv_mute = 1'b0;
        @(negedge clk);
        drive_div(1'b1, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        bus.int_flush = 1'b1;
        #1;
        check_val("flush_stall", 64'(bus.stall_req), 64'd0);
        drive_idle();
        settle(8);
        check_val("flush_hi", 64'(bus.hi), 64'(exp_hi));
        check_val("flush_lo", 64'(bus.lo), 64'(exp_lo));

        // div_ok coincident with flush is discarded.
        dv_mute = 1'b1;
        @(negedge clk);
        drive_div(1'b0, 32'd55, 32'd5);
        @(negedge clk);
        @(negedge clk);
        inj_val = 64'hDEAD_BEEF_CAFE_F00D;
        inj_cnt++;
        @(negedge clk);
        bus.int_flush = 1'b1;
        #1;
        check_val("coinc_ok_seen", 64'(bus.div_ok), 64'd1);
        check_val("coinc_stall", 64'(bus.stall_req), 64'd0);
        drive_idle();
        settle(8);
        check_val("coinc_hi", 64'(bus.hi), 64'(exp_hi));
        check_val("coinc_lo", 64'(bus.lo), 64'(exp_lo));

        // Back-to-back divides.
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0);
        do_div(1'b0, 32'd1000, 32'd0, 1, 1'b0);
        drive_idle();

        // Randomised mix.
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 4);
            lat = $urandom_range(1, 6);
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 31));
            case (op)
                0: do_div(1'b1, a, b, lat, 1'b0);
                1: do_div(1'b0, a, b, lat, 1'b0);
                2: do_mt(1'b1, a);
                3: do_mt(1'b0, a);
                default: drive_idle();
            endcase
        end
        drive_idle();

        // Watchdog: divider never answers.
        do_div(1'b1, 32'd9, 32'd3, 5, 1'b1);
        drive_idle();
        settle(2);
        check_val("tmo_sticky", 64'(bus.div_timeout), 64'd1);

        // Async reset in the middle of BUSY.
        @(negedge clk);
        drive_div(1'b1, 32'h1111_2222, 32'h33);
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_hi  = '0;
        exp_lo  = '0;
        exp_tmo = 1'b0;
        drive_idle();
        resetn = 1'b1;
        settle(8);

        do_div(1'b1, 32'hFFFF_FF00, 32'd16, 4, 1'b0);
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
